// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module : riscv_pkg
// Desc   : Shared opcode, immediate-select, NOP and fetch-state definitions.
// Rev    : 1.0  initial release
// ============================================================================
package riscv_pkg;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_X = 2'b11;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [0:0] {
      ST_FETCH = 1'b0,
      ST_HOLD  = 1'b1
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/imm_sel_decode.sv
`default_nettype none
// ============================================================================
// Module : imm_sel_decode
// Desc   : Combinational opcode to immediate-select decode (shared with decode).
// Rev    : 1.0  initial release
// ============================================================================
module imm_sel_decode
   import riscv_pkg::*;
(
   input  logic [6:0] opcode_i,
   output logic [1:0] immSel_o
);

   always_comb begin
      immSel_o = IMM_X;
      case (opcode_i)
         OP_IMM, LOAD, JALR: immSel_o = IMM_I;
         STORE:              immSel_o = IMM_S;
         BRANCH:             immSel_o = IMM_B;
         default:            immSel_o = IMM_X;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : fetch_stage
// Desc   : PC, instruction-memory request handshake and instruction register.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        rst,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemValid,
   input  logic [31:0] imemData,
   input  logic        idReady,
   input  logic        redirect,
   input  logic [31:0] redirectPC,
   output logic [31:0] instrOut,
   output logic [31:0] pcOut,
   output logic        instrValid,
   output logic [1:0]  immSel
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  pcout_q, pcout_d;

   logic unused_rpc_bits;
   assign unused_rpc_bits = &{1'b0, redirectPC[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         pcout_q <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pcout_q <= pcout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pcout_d = pcout_q;
      case (state_q)
         ST_FETCH: begin
            if (imemValid) begin
               instr_d = imemData;
               pcout_d = pc_q;
               pc_d    = pc_q + 32'd4;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (idReady) state_d = ST_FETCH;
         end
         default: state_d = ST_FETCH;
      endcase
      // Redirect wins: any word returned this cycle is dropped, held regs untouched.
      if (redirect) begin
         instr_d = instr_q;
         pcout_d = pcout_q;
         pc_d    = {redirectPC[31:2], 2'b00};
         state_d = ST_FETCH;
      end
   end

   assign imemReq    = (state_q == ST_FETCH);
   assign imemAddr   = pc_q;
   assign instrValid = (state_q == ST_HOLD);
   assign instrOut   = instr_q;
   assign pcOut      = pcout_q;

   imm_sel_decode u_imm_sel_decode (
      .opcode_i (instr_q[6:0]),
      .immSel_o (immSel)
   );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_stage
// Desc   : Directed plus randomized checks of fetch_stage against a step model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemValid;
   logic [31:0] imemData;
   logic        idReady;
   logic        redirect;
   logic [31:0] redirectPC;
   logic [31:0] instrOut;
   logic [31:0] pcOut;
   logic        instrValid;
   logic [1:0]  immSel;

   int errors = 0;
   int checks = 0;

   // Transaction-level model: is a word held, which word, from where, next PC.
   bit          m_held;
   logic [31:0] m_pc, m_instr, m_pcout;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .imemReq    (imemReq),
      .imemAddr   (imemAddr),
      .imemValid  (imemValid),
      .imemData   (imemData),
      .idReady    (idReady),
      .redirect   (redirect),
      .redirectPC (redirectPC),
      .instrOut   (instrOut),
      .pcOut      (pcOut),
      .instrValid (instrValid),
      .immSel     (immSel)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] exp_sel(input logic [31:0] ins);
      logic [6:0] op;
      op = ins[6:0];
      if (op == 7'h13 || op == 7'h03 || op == 7'h67) return 2'd0;
      if (op == 7'h23) return 2'd1;
      if (op == 7'h63) return 2'd2;
      return 2'd3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("imemReq",    {31'd0, imemReq},    {31'd0, !m_held});
      check("imemAddr",   imemAddr,            m_pc);
      check("instrValid", {31'd0, instrValid}, {31'd0, m_held});
      check("instrOut",   instrOut,            m_instr);
      check("pcOut",      pcOut,               m_pcout);
      check("immSel",     {30'd0, immSel},     {30'd0, exp_sel(m_instr)});
   endtask

   // Drive one cycle of inputs, advance model at the edge, compare at the negedge.
   task automatic cycle(input logic r, input logic v, input logic [31:0] d,
                        input logic rdy, input logic rd, input logic [31:0] rpc);
      rst = r; imemValid = v; imemData = d; idReady = rdy; redirect = rd; redirectPC = rpc;
      @(posedge clk);
      if (r) begin
         m_held = 0; m_pc = 32'h0; m_instr = 32'h13; m_pcout = 32'h0;
      end else if (rd) begin
         m_pc   = rpc & 32'hFFFF_FFFC;
         m_held = 0;
      end else if (!m_held && v) begin
         m_instr = d; m_pcout = m_pc; m_pc = m_pc + 32'd4; m_held = 1;
      end else if (m_held && rdy) begin
         m_held = 0;
      end
      @(negedge clk);
      compare_all();
   endtask

   logic [31:0] ops [8];

   initial begin
      ops[0] = 32'h13; ops[1] = 32'h03; ops[2] = 32'h67; ops[3] = 32'h23;
      ops[4] = 32'h63; ops[5] = 32'h33; ops[6] = 32'h6F; ops[7] = 32'h37;
      m_held = 0; m_pc = 0; m_instr = 32'h13; m_pcout = 0;
      rst = 1; imemValid = 0; imemData = 0; idReady = 0; redirect = 0; redirectPC = 0;

      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      rst = 0;
      @(posedge clk); @(negedge clk);
      compare_all();
      check("rst_req",   {31'd0, imemReq},    32'd1);
      check("rst_addr",  imemAddr,            32'h0);
      check("rst_valid", {31'd0, instrValid}, 32'd0);
      check("rst_instr", instrOut,            32'h0000_0013);

      // I-type, zero-wait memory
      cycle(0, 1, 32'hFFF0_0013, 0, 0, 0);
      check("i_valid", {31'd0, instrValid}, 32'd1);
      check("i_instr", instrOut,            32'hFFF0_0013);
      check("i_sel",   {30'd0, immSel},     32'd0);
      check("i_pcout", pcOut,               32'h0);
      cycle(0, 0, 0, 1, 0, 0);
      check("i_next_addr", imemAddr, 32'h4);

      // S-type with a 3-cycle downstream stall
      cycle(0, 1, 32'hFE11_2E23, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 32'hDEAD_BEEF, 0, 0, 0);
         check("s_sel",   {30'd0, immSel},  32'd1);
         check("s_req",   {31'd0, imemReq}, 32'd0);
         check("s_instr", instrOut,         32'hFE11_2E23);
         check("s_pcout", pcOut,            32'h4);
      end
      cycle(0, 0, 0, 1, 0, 0);
      check("s_next_addr", imemAddr, 32'h8);

      // B-type behind a 3-wait memory: valid rises 4 cycles after first request
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 1, 0, 0);
         check("b_wait_valid", {31'd0, instrValid}, 32'd0);
         check("b_wait_addr",  imemAddr,            32'h8);
      end
      cycle(0, 1, 32'hFE00_0EE3, 0, 0, 0);
      check("b_valid", {31'd0, instrValid}, 32'd1);
      check("b_sel",   {30'd0, immSel},     32'd2);
      check("b_pcout", pcOut,               32'h8);
      cycle(0, 0, 0, 1, 0, 0);

      // Redirect colliding with returned data
      cycle(0, 1, 32'h1234_5013, 0, 1, 32'h0000_0103);
      check("rd_addr",  imemAddr,            32'h0000_0100);
      check("rd_valid", {31'd0, instrValid}, 32'd0);
      check("rd_instr", instrOut,            32'hFE00_0EE3);

      // PC wrap
      cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      check("wrap_addr0", imemAddr, 32'hFFFF_FFFC);
      cycle(0, 1, 32'h0000_0033, 0, 0, 0);
      check("wrap_pcout", pcOut,            32'hFFFF_FFFC);
      check("wrap_sel",   {30'd0, immSel},  32'd3);
      check("wrap_addr",  imemAddr,         32'h0);

      // Randomized traffic; memory only answers while a request is outstanding
      for (int n = 0; n < 3000; n++) begin
         logic        r, v, rdy, rd;
         logic [31:0] d, rpc;
         r   = ($urandom_range(0, 199) == 0);
         rd  = ($urandom_range(0, 15) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         v   = !m_held && ($urandom_range(0, 1) == 1);
         d   = ($urandom & 32'hFFFF_FF80) | ops[$urandom_range(0, 7)];
         rpc = $urandom;
         cycle(r, v, d, rdy, rd, rpc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
